// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm ringer slice: FSM encoding, time width
// and a seconds-of-day wrapping adder.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int              TIME_W      = 17;
  localparam logic [TIME_W-1:0] SEC_PER_DAY = 17'd86400;

  // Add an offset to a seconds-of-day value, wrapping past midnight.
  function automatic logic [TIME_W-1:0] time_add(input logic [TIME_W-1:0] t,
                                                 input logic [TIME_W-1:0] delta);
    logic [TIME_W:0] sum;
    sum = {1'b0, t} + {1'b0, delta};
    if (sum >= {1'b0, SEC_PER_DAY}) begin
      sum = sum - {1'b0, SEC_PER_DAY};
    end
    return sum[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the comparator/keys/pins side (master) and alarm_ringer (slave).
interface alarm_ringer_if;
  import alarm_pkg::*;

  logic              ALARM_DOING;
  logic              SEC_TICK;
  logic [TIME_W-1:0] CURRENT_TIME;
  logic              STOP_KEY;
  logic              SNOOZE_KEY;
  logic              ALARM_ACK;
  logic              RINGING;
  logic              SNOOZING;
  logic              BUZZER;

  modport master (
    output ALARM_DOING, SEC_TICK, CURRENT_TIME, STOP_KEY, SNOOZE_KEY,
    input  ALARM_ACK, RINGING, SNOOZING, BUZZER
  );

  modport slave (
    input  ALARM_DOING, SEC_TICK, CURRENT_TIME, STOP_KEY, SNOOZE_KEY,
    output ALARM_ACK, RINGING, SNOOZING, BUZZER
  );

endinterface

// File: rtl/alarm_tone_gen.sv
// Piezo tone divider: square wave of period 2*TONE_DIV clocks while EN, muted while GATE=0.
// The first enabled clock restarts the divider so every ring starts from a clean phase.
module alarm_tone_gen #(
  parameter int TONE_DIV = 2500
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic EN,
  input  logic GATE,
  output logic BUZZER
);

  localparam int              CNT_W   = $clog2(TONE_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TONE_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             en_reg;
  logic             buzzer_reg;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_reg    <= '0;
      en_reg     <= 1'b0;
      buzzer_reg <= 1'b0;
    end else begin
      en_reg <= EN;
      if (!EN || !en_reg) begin
        cnt_reg    <= '0;
        buzzer_reg <= 1'b0;
      end else if (cnt_reg == CNT_MAX) begin
        cnt_reg    <= '0;
        buzzer_reg <= GATE ? ~buzzer_reg : 1'b0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        if (!GATE) begin
          buzzer_reg <= 1'b0;
        end
      end
    end
  end

  assign BUZZER = buzzer_reg;

endmodule

// File: rtl/alarm_ringer.sv
// Alarm consumer: rising-edge detect on ALARM_DOING, ring/snooze FSM, ring timeout and buzzer.
// Snooze support (SNOOZE state, wake_time, snooze count) is built only with ALARM_SNOOZE_EN.
module alarm_ringer
  import alarm_pkg::*;
#(
  parameter int TONE_DIV       = 2500,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic         CLK,
  input  logic         RESETN,
  alarm_ringer_if.slave bus
);

  localparam int               RSEC_W    = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [RSEC_W-1:0] RSEC_LAST = RSEC_W'(RING_TIMEOUT_S - 1);

  state_t            state_reg, state_next;
  logic              doing_reg;
  logic [RSEC_W-1:0] ring_sec_reg, ring_sec_next;
  logic              beep_phase_reg, beep_phase_next;
  logic              ack_reg, ack_next;
  logic              ringing_reg;
  logic              event_w;
  logic              tone_buzzer;

`ifdef ALARM_SNOOZE_EN
  localparam int              SNZ_W   = $clog2(MAX_SNOOZE + 1);
  localparam logic [SNZ_W-1:0] SNZ_MAX = SNZ_W'(MAX_SNOOZE);

  logic [SNZ_W-1:0]  snooze_cnt_reg, snooze_cnt_next;
  logic [TIME_W-1:0] wake_time_reg, wake_time_next;
  logic              snoozing_reg;
`else
  wire unused_cfg = &{1'b0, bus.SNOOZE_KEY, bus.CURRENT_TIME, SNOOZE_S[0], MAX_SNOOZE[0]};
`endif

  assign event_w = bus.ALARM_DOING & ~doing_reg;

  always_comb begin
    state_next      = state_reg;
    ring_sec_next   = ring_sec_reg;
    beep_phase_next = beep_phase_reg;
    ack_next        = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_next = snooze_cnt_reg;
    wake_time_next  = wake_time_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (event_w) begin
          state_next      = RING;
          ack_next        = 1'b1;
          ring_sec_next   = '0;
          beep_phase_next = 1'b1;
`ifdef ALARM_SNOOZE_EN
          snooze_cnt_next = '0;
`endif
        end
      end
      RING: begin
        if (bus.STOP_KEY) begin
          state_next = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (bus.SNOOZE_KEY && (snooze_cnt_reg < SNZ_MAX)) begin
          state_next      = SNOOZE;
          snooze_cnt_next = snooze_cnt_reg + SNZ_W'(1);
          wake_time_next  = time_add(bus.CURRENT_TIME, TIME_W'(SNOOZE_S));
`endif
        end else begin
          if (bus.SEC_TICK) begin
            beep_phase_next = ~beep_phase_reg;
          end
          // A retrigger restarts the timeout window even if a tick lands on the same clock.
          if (event_w) begin
            ack_next      = 1'b1;
            ring_sec_next = '0;
          end else if (bus.SEC_TICK) begin
            if (ring_sec_reg == RSEC_LAST) begin
              state_next = IDLE;
            end else begin
              ring_sec_next = ring_sec_reg + RSEC_W'(1);
            end
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (bus.STOP_KEY) begin
          state_next = IDLE;
        end else if (event_w) begin
          state_next      = RING;
          ack_next        = 1'b1;
          snooze_cnt_next = '0;
          ring_sec_next   = '0;
          beep_phase_next = 1'b1;
        end else if (bus.CURRENT_TIME == wake_time_reg) begin
          state_next      = RING;
          ring_sec_next   = '0;
          beep_phase_next = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg      <= IDLE;
      doing_reg      <= 1'b0;
      ring_sec_reg   <= '0;
      beep_phase_reg <= 1'b0;
      ack_reg        <= 1'b0;
      ringing_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      doing_reg      <= bus.ALARM_DOING;
      ring_sec_reg   <= ring_sec_next;
      beep_phase_reg <= beep_phase_next;
      ack_reg        <= ack_next;
      ringing_reg    <= (state_next == RING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      snooze_cnt_reg <= '0;
      wake_time_reg  <= '0;
      snoozing_reg   <= 1'b0;
    end else begin
      snooze_cnt_reg <= snooze_cnt_next;
      wake_time_reg  <= wake_time_next;
      snoozing_reg   <= (state_next == SNOOZE);
    end
  end

  assign bus.SNOOZING = snoozing_reg;
`else
  assign bus.SNOOZING = 1'b0;
`endif

  // Tone is driven from next-state values so BUZZER stays aligned with RINGING.
  alarm_tone_gen #(
    .TONE_DIV (TONE_DIV)
  ) u_tone (
    .CLK    (CLK),
    .RESETN (RESETN),
    .EN     (state_next == RING),
    .GATE   (beep_phase_next),
    .BUZZER (tone_buzzer)
  );

  assign bus.ALARM_ACK = ack_reg;
  assign bus.RINGING   = ringing_reg;
  assign bus.BUZZER    = tone_buzzer;

endmodule
